uart_rx_core: RTL and testbench

//  UART receive engine driven by the config/status register file. Consumes uart_enable/uart_mode/uart_rate.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_core_bit_timer.sv | 43 ++++
 rtl/uart_rx_core.sv | 151 +++++++++++++++
 tb/tb_uart_rx_core.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    WAIT_IDLE
  } rx_state_e;

  localparam int unsigned MODE_PAR_EN_BIT  = 0;
  localparam int unsigned MODE_PAR_ODD_BIT = 1;
  localparam int unsigned MODE_STOP2_BIT   = 2;
  localparam int unsigned MIN_RATE         = 4;

endpackage

// File: rtl/uart_rx_core_bit_timer.sv
// Bit-period down-counter: loads a half period at start detect, then ticks once per full period.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int unsigned RATE_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  input  logic                  load_i,
  input  logic                  run_i,
  output logic                  tick_o
);

  logic [RATE_WIDTH-1:0] eff_rate;
  logic [RATE_WIDTH-1:0] rate_q, rate_d;
  logic [RATE_WIDTH-1:0] cnt_q, cnt_d;

  assign eff_rate = (rate_i < RATE_WIDTH'(MIN_RATE)) ? RATE_WIDTH'(MIN_RATE) : rate_i;
  assign tick_o   = run_i && (cnt_q == '0);

  always_comb begin
    rate_d = rate_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      rate_d = eff_rate;
      cnt_d  = (eff_rate >> 1) - RATE_WIDTH'(1);
    end else if (run_i) begin
      cnt_d = (cnt_q == '0) ? rate_q - RATE_WIDTH'(1) : cnt_q - RATE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rate_q <= RATE_WIDTH'(MIN_RATE);
      cnt_q  <= '0;
    end else begin
      rate_q <= rate_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine with 1-entry valid/ready holding register.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote per bit, decision one cycle after nominal.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned RATE_WIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_serial,
  input  logic                  uart_enable,
  input  logic [2:0]            uart_mode,
  input  logic [RATE_WIDTH-1:0] uart_rate,
  output logic [DATA_BITS-1:0]  rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  uart_busy,
  output logic                  uart_error,
  output logic                  update_ok
);

  localparam int unsigned CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  line;
  logic [2:0]            mode_q;
  logic [CW-1:0]         bitcnt_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  par_q, perr_q;
  logic [DATA_BITS-1:0]  rx_data_q;
  logic                  rx_valid_q, err_q;
  logic                  tick, sample_en, sample_bit;
  logic                  start_det, timer_run, frame_end, frame_good, load_word, err_d;

  assign line = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
  end

  uart_bit_timer #(.RATE_WIDTH(RATE_WIDTH)) u_timer (
    .clk_i  (clk),
    .rst_i  (rst),
    .rate_i (uart_rate),
    .load_i (start_det),
    .run_i  (timer_run),
    .tick_o (tick)
  );

`ifdef UART_RX_MAJORITY_EN
  // hist_q holds the line at nominal-1 and nominal when the delayed tick fires at nominal+1.
  logic [1:0] hist_q;
  logic       tick_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '1;
      tick_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], line};
      tick_q <= tick;
    end
  end
  assign sample_en  = tick_q;
  assign sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);
`else
  assign sample_en  = tick;
  assign sample_bit = line;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!uart_enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      if (!line) state_d = START;
        START:     if (sample_en) state_d = sample_bit ? IDLE : DATA;
        DATA:      if (sample_en && (bitcnt_q == CW'(DATA_BITS - 1)))
                     state_d = mode_q[MODE_PAR_EN_BIT] ? PARITY : STOP1;
        PARITY:    if (sample_en) state_d = STOP1;
        STOP1:     if (sample_en)
                     state_d = !sample_bit ? WAIT_IDLE : (mode_q[MODE_STOP2_BIT] ? STOP2 : IDLE);
        STOP2:     if (sample_en) state_d = sample_bit ? IDLE : WAIT_IDLE;
        WAIT_IDLE: if (line) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    uart_busy  = (state_q != IDLE);
    update_ok  = (state_q == IDLE) && line;
    start_det  = (state_q == IDLE) && uart_enable && !line;
    timer_run  = (state_q == START) || (state_q == DATA) || (state_q == PARITY) ||
                 (state_q == STOP1) || (state_q == STOP2);
    frame_end  = uart_enable && sample_en &&
                 (((state_q == STOP1) && (!sample_bit || !mode_q[MODE_STOP2_BIT])) ||
                  (state_q == STOP2));
    frame_good = sample_bit && !perr_q;
    load_word  = frame_end && frame_good && (!rx_valid_q || rx_ready);
    err_d      = frame_end && (!frame_good || (rx_valid_q && !rx_ready));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= '0;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      perr_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (start_det) begin
        mode_q <= uart_mode;
        par_q  <= 1'b0;
        perr_q <= 1'b0;
      end
      if (sample_en && (state_q == START)) bitcnt_q <= '0;
      if (sample_en && (state_q == DATA)) begin
        shift_q  <= {sample_bit, shift_q[DATA_BITS-1:1]};
        par_q    <= par_q ^ sample_bit;
        bitcnt_q <= bitcnt_q + CW'(1);
      end
      if (sample_en && (state_q == PARITY))
        perr_q <= ((par_q ^ sample_bit) != mode_q[MODE_PAR_ODD_BIT]);
      if (load_word) begin
        rx_data_q  <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign uart_error = err_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench: frame driver pushes expected word/error events, a negedge monitor pops and compares.
module tb_uart_rx_core;

`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_serial;
  logic        uart_enable;
  logic [2:0]  uart_mode;
  logic [15:0] uart_rate;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        uart_busy;
  logic        uart_error;
  logic        update_ok;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         at;
  } ev_t;
  ev_t exp_q[$];

  uart_rx_core #(.DATA_BITS(8), .RATE_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_serial   (rx_serial),
    .uart_enable (uart_enable),
    .uart_mode   (uart_mode),
    .uart_rate   (uart_rate),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .uart_busy   (uart_busy),
    .uart_error  (uart_error),
    .update_ok   (update_ok)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_cycle(input int c);
    if (cyc > c) begin
      checks++;
      errors++;
      $display("FAIL at_cycle: now %0d past target %0d", cyc, c);
    end else begin
      do @(negedge clk); while (cyc < c);
    end
  endtask

  // Reference model: frame end is the last (or failing) stop sample, at T + eff/2 + eff*index.
  task automatic send_frame(input logic [7:0] data, input logic [2:0] mode, input int rate,
                            input bit bad_par, input bit bad_stop1, input bit bad_stop2,
                            input int hold_low, input bit expect_ev, input bit overrun,
                            input int gbit);
    bit q[$];
    int eff, h, t, last, fe;
    bit good;
    ev_t e;
    eff = (rate < 4) ? 4 : rate;
    h   = eff / 2;
    t   = cyc + 2;
    uart_mode = mode;
    uart_rate = 16'(rate);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(data[i]);
    if (mode[0]) q.push_back((^data) ^ mode[1] ^ bad_par);
    q.push_back(!bad_stop1);
    if (mode[2] && !bad_stop1) q.push_back(!bad_stop2);
    last = q.size() - 1;
    good = !(mode[0] && bad_par) && !bad_stop1 && !(mode[2] && bad_stop2);
    fe   = t + h + eff * last + MAJ;
    if (expect_ev) begin
      if (good && !overrun) begin
        e.is_err = 1'b0; e.data = data; e.at = fe + 1;
        exp_q.push_back(e);
      end
      if (!good || overrun) begin
        e.is_err = 1'b1; e.data = '0; e.at = fe + 1;
        exp_q.push_back(e);
      end
    end
    for (int j = 0; j < q.size(); j++)
      for (int c = 0; c < eff; c++) begin
        rx_serial = q[j] ^ ((j == gbit) && (c == h));
        step();
      end
    if (bad_stop1) repeat (hold_low) step();
    rx_serial = 1'b1;
  endtask

  bit prev_valid, prev_xfer;

  task automatic pop_check(input bit is_err);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s event expected none (cycle %0d)",
               is_err ? "error" : "word", cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(is_err), 32'(e.is_err));
      check("event_cycle", cyc, e.at);
      if (!is_err) check("rx_data", 32'(rx_data), 32'(e.data));
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (rx_valid && (!prev_valid || prev_xfer)) pop_check(1'b0);
      if (uart_error) pop_check(1'b1);
      prev_valid = rx_valid;
      prev_xfer  = rx_valid && rx_ready;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [2:0] m;
    rst = 1'b1; rx_serial = 1'b1; uart_enable = 1'b1;
    uart_mode = '0; uart_rate = 16'd16; rx_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("reset_rx_valid", 32'(rx_valid), 0);
    check("reset_rx_data", 32'(rx_data), 0);
    check("reset_busy", 32'(uart_busy), 0);
    check("reset_error", 32'(uart_error), 0);
    check("reset_update_ok", 32'(update_ok), 1);
    step();
    rst = 1'b0;
    repeat (4) step();

    // basic frame with busy window
    t = cyc + 2;
    fork
      send_frame(8'hA5, 3'b000, 16, 0, 0, 0, 0, 1, 0, -1);
      begin
        at_cycle(t);            check("busy_at_T", 32'(uart_busy), 0);
        at_cycle(t + 1);        check("busy_T+1", 32'(uart_busy), 1);
        at_cycle(t + 152 + MAJ); check("busy_last", 32'(uart_busy), 1);
        at_cycle(t + 153 + MAJ); check("busy_end", 32'(uart_busy), 0);
      end
    join
    repeat (5) step();

    // odd parity with a wrong parity bit
    send_frame(8'h0F, 3'b011, 16, 1, 0, 0, 0, 1, 0, -1);
    repeat (5) step();
    check("parity_no_valid", 32'(rx_valid), 0);

    // framing error, line held low afterwards
    t = cyc + 2;
    fork
      send_frame(8'h3C, 3'b000, 16, 0, 1, 0, 40, 1, 0, -1);
      begin
        at_cycle(t + 195); check("wait_idle_busy", 32'(uart_busy), 1);
                           check("wait_idle_upd", 32'(update_ok), 0);
        at_cycle(t + 202); check("recover_busy", 32'(uart_busy), 0);
                           check("recover_upd", 32'(update_ok), 1);
      end
    join
    repeat (5) step();

    // overrun, then reset clears the holding register
    rx_ready = 1'b0;
    send_frame(8'h11, 3'b000, 16, 0, 0, 0, 0, 1, 0, -1);
    repeat (4) step();
    send_frame(8'h22, 3'b000, 16, 0, 0, 0, 0, 1, 1, -1);
    repeat (4) step();
    @(negedge clk);
    check("overrun_valid", 32'(rx_valid), 1);
    check("overrun_data", 32'(rx_data), 32'h11);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midreset_valid", 32'(rx_valid), 0);
    check("midreset_data", 32'(rx_data), 0);
    rx_ready = 1'b1;
    repeat (4) step();

    // false start glitch
    t = cyc + 2;
    rx_serial = 1'b0;
    repeat (3) step();
    rx_serial = 1'b1;
    at_cycle(t + 8 + MAJ); check("glitch_busy", 32'(uart_busy), 1);
    at_cycle(t + 9 + MAJ); check("glitch_idle", 32'(uart_busy), 0);
    repeat (20) step();

    // rate rewrite mid-frame
    t = cyc + 2;
    fork
      send_frame(8'hC3, 3'b000, 16, 0, 0, 0, 0, 1, 0, -1);
      begin at_cycle(t + 50); uart_rate = 16'd8; end
    join
    uart_rate = 16'd16;
    repeat (5) step();

    // enable dropped mid-frame
    t = cyc + 2;
    fork
      send_frame(8'h5A, 3'b000, 16, 0, 0, 0, 0, 0, 0, -1);
      begin
        at_cycle(t + 60); uart_enable = 1'b0;
        at_cycle(t + 61); check("disable_idle", 32'(uart_busy), 0);
      end
    join
    repeat (3) step();
    uart_enable = 1'b1;
    repeat (3) step();

    // rate below minimum
    send_frame(8'h96, 3'b000, 2, 0, 0, 0, 0, 1, 0, -1);
    repeat (5) step();

`ifdef UART_RX_MAJORITY_EN
    send_frame(8'hA5, 3'b000, 16, 0, 0, 0, 0, 1, 0, 4);
    repeat (5) step();
`endif

    for (int n = 0; n < 24; n++) begin
      m = 3'($urandom_range(0, 7));
      send_frame(8'($urandom), m, $urandom_range(2, 12),
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 5) == 0), $urandom_range(0, 6), 1, 0, -1);
      repeat ($urandom_range(1, 6)) step();
    end

    repeat (40) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
